md_unit: RTL and testbench

- Multiply/divide unit in the E stage of the five-stage MIPS pipeline.
- Consumes the 4-bit `start` code that the D-stage controller emits (carried down the pipeline) and owns the HI/LO registers.
- Models multi-cycle latency with a busy flag so hazard logic can stall MDU instructions in D.
- Returns HI or LO for mfhi/mflo on a combinational read port.

---
 rtl/md_pkg.sv | 42 ++++
 rtl/md_arith.sv | 58 +++++
 rtl/md_unit.sv | 111 +++++++++++
 tb/tb_md_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   - E-stage start codes (MD_NONE..MD_MTLO)
//   - default busy latencies for multiply and divide
//   - FSM state type
//   - helpers: arithmetic-op decode and the mfhi/mflo read-port select
package md_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } md_state_e;

    // True for the multi-cycle ops (mult, multu, div, divu).
    function automatic logic md_is_arith(input logic [3:0] code);
        return (code >= MD_MULT) && (code <= MD_DIVU);
    endfunction

    // Read port: HI for mfhi, LO for mflo, zero for every other code.
    function automatic logic [31:0] md_out_sel(input logic [3:0]  code,
                                               input logic [31:0] hi,
                                               input logic [31:0] lo);
        case (code)
            MD_MFHI: return hi;
            MD_MFLO: return lo;
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: purely combinational multiply/divide datapath.
// Ports:
//   i_a, i_b    32-bit operands (rs, rt)
//   i_op        start code; only mult/multu/div/divu produce a non-zero result
//   o_result    {hi, lo}: product for multiplies, {remainder, quotient} for divides
//   o_div_zero  divide op with a zero divisor
module md_arith
    import md_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [3:0]  i_op,
    output logic [63:0] o_result,
    output logic        o_div_zero
);

    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic               w_b_zero;
    logic               w_ovf;
    logic        [31:0] w_b_udiv;
    logic        [31:0] w_b_sdiv;
    logic signed [31:0] w_quot_s;
    logic signed [31:0] w_rem_s;
    logic        [31:0] w_quot_u;
    logic        [31:0] w_rem_u;

    assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_prod_u = {32'h0, i_a} * {32'h0, i_b};

    assign w_b_zero = (i_b == 32'h0);
    assign w_ovf    = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

    // Zero divisors are replaced so the dividers never see /0; the result is discarded.
    // For 0x80000000 / -1, dividing by 1 yields exactly the wanted LO=0x80000000, HI=0.
    assign w_b_udiv = w_b_zero ? 32'h1 : i_b;
    assign w_b_sdiv = (w_b_zero || w_ovf) ? 32'h1 : i_b;

    // SystemVerilog signed / and % truncate toward zero; remainder follows the dividend.
    assign w_quot_s = $signed(i_a) / $signed(w_b_sdiv);
    assign w_rem_s  = $signed(i_a) % $signed(w_b_sdiv);
    assign w_quot_u = i_a / w_b_udiv;
    assign w_rem_u  = i_a % w_b_udiv;

    assign o_div_zero = w_b_zero && ((i_op == MD_DIV) || (i_op == MD_DIVU));

    always_comb begin
        o_result = 64'h0;
        case (i_op)
            MD_MULT:  o_result = w_prod_s;
            MD_MULTU: o_result = w_prod_u;
            MD_DIV:   o_result = {w_rem_s, w_quot_s};
            MD_DIVU:  o_result = {w_rem_u, w_quot_u};
            default:  o_result = 64'h0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit owning HI/LO.
// Ports:
//   clk     pipeline clock
//   reset   asynchronous active-low reset
//   start   E-stage op code (see md_pkg)
//   A, B    forwarded rs / rt values
//   flush   cancels the E-stage op this cycle (an op already in flight still commits)
//   launch  combinational: arithmetic op accepted this cycle
//   busy    registered: an op is in flight
//   out     combinational mfhi/mflo read port
// Results are computed at launch and held in pending registers; HI/LO only change
// at the edge that ends the last busy cycle. Hazard logic stalls on busy | launch.
// MULT_CYCLES and DIV_CYCLES must be at least 1.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    output logic        launch,
    output logic        busy,
    output logic [31:0] out
);

    localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    md_state_e          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_pend_hi;
    logic [31:0]        r_pend_lo;
    logic               r_pend_dz;
    logic               r_busy;

    logic [63:0]        w_result;
    logic               w_div_zero;
    logic               w_idle;
    logic               w_is_mult;

    md_arith u_arith (
        .i_a        (A),
        .i_b        (B),
        .i_op       (start),
        .o_result   (w_result),
        .o_div_zero (w_div_zero)
    );

    assign w_idle    = (r_state == StIdle);
    assign w_is_mult = (start == MD_MULT) || (start == MD_MULTU);

    assign launch = md_is_arith(start) && !flush && w_idle;
    assign busy   = r_busy;
    assign out    = md_out_sel(start, r_hi, r_lo);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_hi      <= 32'h0;
            r_lo      <= 32'h0;
            r_pend_hi <= 32'h0;
            r_pend_lo <= 32'h0;
            r_pend_dz <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (launch) begin
                        r_pend_hi <= w_result[63:32];
                        r_pend_lo <= w_result[31:0];
                        r_pend_dz <= w_div_zero;
                        r_cnt     <= w_is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        r_busy    <= 1'b1;
                        r_state   <= StBusy;
                    end else if (!flush && (start == MD_MTHI)) begin
                        r_hi <= A;
                    end else if (!flush && (start == MD_MTLO)) begin
                        r_lo <= A;
                    end
                end
                StBusy: begin
                    // All start codes are ignored here; flush does not cancel the op.
                    if (r_cnt == CNT_W'(1)) begin
                        if (!r_pend_dz) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (MULT_CYCLES=5, DIV_CYCLES=10).
module tb_md_unit;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  start;
    logic [31:0] A;
    logic [31:0] B;
    logic        flush;
    logic        launch;
    logic        busy;
    logic [31:0] out;

    int checks;
    int failures;

    md_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .A      (A),
        .B      (B),
        .flush  (flush),
        .launch (launch),
        .busy   (busy),
        .out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        start = MD_MFHI;
        #1 hi = out;
        start = MD_MFLO;
        #1 lo = out;
        start = MD_NONE;
        #1;
    endtask

    task automatic write_hilo(input logic [31:0] hi, input logic [31:0] lo);
        start = MD_MTHI; A = hi;
        tick();
        start = MD_MTLO; A = lo;
        tick();
        start = MD_NONE;
    endtask

    // Issues one op and counts the cycles busy stays high (bounded at 100).
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic launched, output int n);
        start = op; A = a; B = b;
        #1 launched = launch;
        tick();
        start = MD_NONE;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset;
        logic [31:0] hi, lo;
        reset = 1'b0; start = MD_NONE; flush = 1'b0; A = '0; B = '0;
        #3;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (launch !== 1'b0) begin failures++; $display("FAIL reset_launch got=%b exp=0", launch); end
        read_hilo(hi, lo);
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_mult;
        logic [31:0] hi, lo; logic l; int n;
        run_op(MD_MULT, 32'hFFFF_FFFD, 32'd5, l, n);
        read_hilo(hi, lo);
        checks++; if (l !== 1'b1) begin failures++; $display("FAIL mult_launch got=%b exp=1", l); end
        checks++; if (n != 5) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=5", n); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFF1) begin failures++; $display("FAIL mult_lo got=%h exp=fffffff1", lo); end
        run_op(MD_MULTU, 32'hFFFF_FFFD, 32'd5, l, n);
        read_hilo(hi, lo);
        checks++; if (n != 5) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=5", n); end
        checks++; if (hi !== 32'h0000_0004) begin failures++; $display("FAIL multu_hi got=%h exp=00000004", hi); end
        checks++; if (lo !== 32'hFFFF_FFF1) begin failures++; $display("FAIL multu_lo got=%h exp=fffffff1", lo); end
    endtask

    task automatic test_div;
        logic [31:0] hi, lo; logic l; int n;
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, l, n);
        read_hilo(hi, lo);
        checks++; if (n != 10) begin failures++; $display("FAIL div_busy_cycles got=%0d exp=10", n); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
        run_op(MD_DIVU, 32'd7, 32'd2, l, n);
        read_hilo(hi, lo);
        checks++; if (n != 10) begin failures++; $display("FAIL divu_busy_cycles got=%0d exp=10", n); end
        checks++; if (lo !== 32'd3) begin failures++; $display("FAIL divu_lo got=%h exp=00000003", lo); end
        checks++; if (hi !== 32'd1) begin failures++; $display("FAIL divu_hi got=%h exp=00000001", hi); end
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, l, n);
        read_hilo(hi, lo);
        checks++; if (lo !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL div_ovf_hi got=%h exp=00000000", hi); end
    endtask

    task automatic test_mthi_mtlo;
        start = MD_MTHI; A = 32'h1234_5678;
        #1;
        checks++; if (launch !== 1'b0) begin failures++; $display("FAIL mthi_launch got=%b exp=0", launch); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mthi_busy got=%b exp=0", busy); end
        start = MD_MFHI;
        #1;
        checks++; if (out !== 32'h1234_5678) begin failures++; $display("FAIL mfhi_out got=%h exp=12345678", out); end
        start = MD_MTLO; A = 32'hCAFE_BABE;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mtlo_busy got=%b exp=0", busy); end
        start = MD_MFLO;
        #1;
        checks++; if (out !== 32'hCAFE_BABE) begin failures++; $display("FAIL mflo_out got=%h exp=cafebabe", out); end
        start = 4'd9;
        #1;
        checks++; if (out !== 32'h0) begin failures++; $display("FAIL code9_out got=%h exp=0", out); end
        checks++; if (launch !== 1'b0) begin failures++; $display("FAIL code9_launch got=%b exp=0", launch); end
        start = MD_NONE;
    endtask

    task automatic test_div_zero;
        logic [31:0] hi, lo; logic l; int n;
        write_hilo(32'h11, 32'h22);
        run_op(MD_DIVU, 32'd9, 32'd0, l, n);
        read_hilo(hi, lo);
        checks++; if (l !== 1'b1) begin failures++; $display("FAIL divz_launch got=%b exp=1", l); end
        checks++; if (n != 10) begin failures++; $display("FAIL divz_busy_cycles got=%0d exp=10", n); end
        checks++; if (hi !== 32'h11) begin failures++; $display("FAIL divz_hi got=%h exp=00000011", hi); end
        checks++; if (lo !== 32'h22) begin failures++; $display("FAIL divz_lo got=%h exp=00000022", lo); end
    endtask

    task automatic test_flush;
        logic [31:0] hi, lo;
        flush = 1'b1; start = MD_MULT; A = 32'd3; B = 32'd4;
        #1;
        checks++; if (launch !== 1'b0) begin failures++; $display("FAIL flush_launch got=%b exp=0", launch); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end
        start = MD_MTHI; A = 32'h99;
        tick();
        flush = 1'b0; start = MD_NONE;
        read_hilo(hi, lo);
        checks++; if (hi !== 32'h11) begin failures++; $display("FAIL flush_hi got=%h exp=00000011", hi); end
        checks++; if (lo !== 32'h22) begin failures++; $display("FAIL flush_lo got=%h exp=00000022", lo); end
    endtask

    task automatic test_flush_in_flight;
        logic [31:0] hi, lo; int n;
        start = MD_DIVU; A = 32'd100; B = 32'd7;
        #1;
        tick();
        start = MD_NONE;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            flush = (n == 2);
            n++;
            tick();
        end
        flush = 1'b0;
        read_hilo(hi, lo);
        checks++; if (n != 10) begin failures++; $display("FAIL flight_busy_cycles got=%0d exp=10", n); end
        checks++; if (lo !== 32'd14) begin failures++; $display("FAIL flight_lo got=%h exp=0000000e", lo); end
        checks++; if (hi !== 32'd2) begin failures++; $display("FAIL flight_hi got=%h exp=00000002", hi); end
    endtask

    task automatic test_ignored_while_busy;
        logic [31:0] hi, lo; int n;
        start = MD_MULT; A = 32'd6; B = 32'd7;
        #1;
        tick();
        start = MD_NONE;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (n == 1) begin
                start = MD_MTLO; A = 32'hDEAD;
            end else if (n == 2) begin
                start = MD_MULT; A = 32'd100; B = 32'd100;
                #1;
                checks++; if (launch !== 1'b0) begin failures++; $display("FAIL busy_launch got=%b exp=0", launch); end
            end else if (n == 3) begin
                start = MD_MFHI;
                #1;
                checks++; if (out !== 32'd2) begin failures++; $display("FAIL busy_old_hi got=%h exp=00000002", out); end
            end else begin
                start = MD_NONE;
            end
            n++;
            tick();
        end
        start = MD_NONE;
        read_hilo(hi, lo);
        checks++; if (n != 5) begin failures++; $display("FAIL ign_busy_cycles got=%0d exp=5", n); end
        checks++; if (lo !== 32'd42) begin failures++; $display("FAIL ign_lo got=%h exp=0000002a", lo); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL ign_hi got=%h exp=00000000", hi); end
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] hi, lo;
        write_hilo(32'h55, 32'h66);
        start = MD_DIV; A = 32'hFFFF_FFF9; B = 32'd2;
        #1;
        tick();
        start = MD_NONE;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        read_hilo(hi, lo);
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL rst_mid_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL rst_mid_lo got=%h exp=0", lo); end
        reset = 1'b1;
        repeat (12) tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_after_busy got=%b exp=0", busy); end
        read_hilo(hi, lo);
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin
            failures++; $display("FAIL rst_after_hilo got=%h_%h exp=0_0", hi, lo);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] hi, lo; logic l; int n;
        run_op(MD_MULTU, 32'h0001_0000, 32'h0001_0000, l, n);
        read_hilo(hi, lo);
        checks++; if (hi !== 32'h1 || lo !== 32'h0) begin
            failures++; $display("FAIL b2b_mul got=%h_%h exp=00000001_00000000", hi, lo);
        end
        run_op(MD_DIVU, 32'hFFFF_FFFF, 32'h10, l, n);
        read_hilo(hi, lo);
        checks++; if (l !== 1'b1) begin failures++; $display("FAIL b2b_launch got=%b exp=1", l); end
        checks++; if (n != 10) begin failures++; $display("FAIL b2b_busy_cycles got=%0d exp=10", n); end
        checks++; if (hi !== 32'hF || lo !== 32'h0FFF_FFFF) begin
            failures++; $display("FAIL b2b_div got=%h_%h exp=0000000f_0fffffff", hi, lo);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_div_zero();
        test_flush();
        test_flush_in_flight();
        test_ignored_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
